btime_rom_loader: RTL and testbench
===================================

# btime_rom_loader

Sits between the HPS download stream and the `burger_time` core's `dn_addr`/`dn_data`/`dn_wr` port, and owns the core's reset.
- Registers each downloaded byte and bounds-checks it against the ROM image size.
- Enforces strictly sequential addressing from 0.
- Holds the game in reset for the whole download, then for a settle period after it.
- Releases reset only if a complete, error-free image was loaded.

## Interface
Parameters:
- `ROM_SIZE`, default 57344: exact image length in bytes. Legal range 1..131072.
- `RESET_HOLD`, default 1024: `clk_sys` cycles that `game_reset` stays high after a good download ends. Legal range 1..65535.

Ports:
- `clk_sys`  in  1  system clock (12 MHz). The only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ext_reset`  in  1  synchronous request to restart the game (system reset OR menu reset OR user button). Active-high, level.
- `ioctl_download`  in  1  download window active.
- `ioctl_wr`  in  1  single-cycle byte strobe. Can be high on consecutive cycles.
- `ioctl_addr`  in  25  byte address of `ioctl_dout`.
- `ioctl_dout`  in  8  download byte.
- `dn_addr`  out  17  registered write address to the core.
- `dn_data`  out  8  registered write data to the core.
- `dn_wr`  out  1  registered write strobe to the core, one cycle per accepted byte.
- `game_reset`  out  1  active-high reset to the core.
- `rom_ok`  out  1  last download complete, sequential and in range.
- `err_overflow`  out  1  sticky: a byte arrived with address ≥ ROM_SIZE.
- `err_seq`  out  1  sticky: a byte address differed from the expected next address.
- `byte_count`  out  18  count of accepted bytes in the current or last download.

## Operation
Reset values, all outputs:
- `game_reset`=1.
- `dn_wr`=0, `dn_addr`=0, `dn_data`=0.
- `rom_ok`=0, `err_overflow`=0, `err_seq`=0, `byte_count`=0.
- State = IDLE.

FSM states: IDLE, LOAD, HOLD, RUN, FAULT.
- IDLE: no valid image; `game_reset`=1. Rising edge of `ioctl_download` → LOAD.
- LOAD: `game_reset`=1.
  - On entry, clear `byte_count`, both error flags and `rom_ok`, and set expected address = 0.
  - Falling edge of `ioctl_download` → HOLD. The hold counter loads `RESET_HOLD`-1, and `rom_ok` is set to (`byte_count`==`ROM_SIZE` && !`err_overflow` && !`err_seq`). This evaluation includes a byte accepted in the same cycle as the falling edge.
- HOLD:
  - If `rom_ok`=0 → FAULT immediately.
  - Otherwise the counter decrements once per cycle; when it reads 0 → RUN.
  - `game_reset`=1 throughout.
- RUN: `game_reset`=0.
  - `ext_reset`=1 → HOLD, reloading the counter; `rom_ok` is unchanged.
  - `ioctl_download` rising → LOAD.
- FAULT: `game_reset`=1 permanently. `ioctl_download` rising → LOAD is the only exit.
- From any state, a rising edge of `ioctl_download` goes to LOAD, and that transition has priority over `ext_reset`.
- Download edges are detected with a registered copy of `ioctl_download`.

Byte handling applies only when `ioctl_wr`=1 in LOAD, or in the same cycle that LOAD is entered:
- If `ioctl_addr` ≥ `ROM_SIZE`: set `err_overflow`, no `dn_wr`, `byte_count` unchanged.
- Otherwise, if `ioctl_addr` ≠ expected: set `err_seq`, but still write the byte (`dn_wr`=1) and increment `byte_count`. Expected becomes `ioctl_addr`+1.
- Otherwise: `dn_wr`=1, `dn_addr`=`ioctl_addr[16:0]`, `dn_data`=`ioctl_dout`, `byte_count`+1, expected+1.
- `ioctl_wr` outside LOAD is ignored.

Width rules:
- The address compare uses the full 25 bits. Upper bits set counts as overflow and never aliases into the 17-bit space.
- `byte_count` saturates at 2^18-1.

## Timing
- `dn_wr`, `dn_addr` and `dn_data` change exactly 1 cycle after the `ioctl_wr` sample. `dn_wr` is high for exactly 1 cycle per accepted byte; back-to-back input strobes give back-to-back `dn_wr`.
- `dn_addr` and `dn_data` hold their last values while `dn_wr`=0.
- `ioctl_download` falling at cycle T:
  - `rom_ok` is valid at T+1.
  - Good image: `game_reset` falls at T+1+`RESET_HOLD`.
  - Bad image: FAULT at T+2.
- `ext_reset` in RUN: `game_reset`=1 the next cycle. It stays high for `RESET_HOLD` cycles after `ext_reset` is sampled low. While `ext_reset` stays high, HOLD keeps reloading the counter.
- `reset_n` asserted mid-download: everything returns to reset values asynchronously. A still-active download is then treated as IDLE until the next rising edge of `ioctl_download`.

## Test plan
- Sequential download of addresses 0..57343, data = addr[7:0], 1 byte per cycle → 57344 `dn_wr` pulses, each 1 cycle after its strobe with matching addr/data; `rom_ok`=1; `game_reset` falls 1025 cycles after the download ends.
- Extra byte at address 57344 → `err_overflow`=1, no `dn_wr` for that byte, `rom_ok`=0, FAULT, `game_reset` stays 1.
- Addresses 0, 1, 3, …, gap, total length correct → `err_seq`=1, `rom_ok`=0, `game_reset` stays 1; a following clean download → RUN.
- In RUN, pulse `ext_reset` for 5 cycles → `game_reset`=1 from the next cycle, falling `RESET_HOLD` cycles after `ext_reset` drops.
- Drop `reset_n` midway through LOAD (at byte 1000), release it, then start a fresh clean download → all flags 0 right after reset; the second download reaches RUN with `byte_count`=57344.
- `ioctl_wr` and the `ioctl_download` falling edge in the same cycle at address 57343 → the byte is written and `rom_ok`=1.

Source files
------------

// File: rtl/btime_rom_loader.sv
// Download front-end for the burger_time core: registers and bounds-checks ROM bytes,
// enforces sequential addressing and owns the core reset until a good image is loaded.
module btime_rom_loader #(
   parameter int unsigned ROM_SIZE   = 57344,
   parameter int unsigned RESET_HOLD = 1024
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ext_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [16:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic        game_reset,
   output logic        rom_ok,
   output logic        err_overflow,
   output logic        err_seq,
   output logic [17:0] byte_count
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_FAULT} state_t;

   localparam logic [24:0] ROM_END = 25'(ROM_SIZE);
   localparam logic [17:0] ROM_LEN = 18'(ROM_SIZE);
   localparam logic [15:0] HOLD_LD = 16'(RESET_HOLD - 1);

   state_t      state, state_nxt;
   logic        dl_q, dl_rise, dl_fall;
   logic [24:0] exp_addr, base_exp, exp_nxt;
   logic [15:0] hold_cnt, hold_nxt;
   logic [17:0] base_cnt, cnt_nxt;
   logic        base_ovf, base_seq, ovf_nxt, seq_nxt, ok_nxt;
   logic        take, in_range, wr_ok;

   assign dl_rise    = ioctl_download & ~dl_q;
   assign dl_fall    = ~ioctl_download & dl_q;
   assign game_reset = (state != S_RUN);

   // A byte arriving on the LOAD-entry cycle is judged against freshly cleared
   // bookkeeping, so the "base" values fold in the entry clear.
   always_comb begin
      take     = ioctl_wr && (state == S_LOAD || dl_rise);
      base_cnt = dl_rise ? '0 : byte_count;
      base_exp = dl_rise ? '0 : exp_addr;
      base_ovf = dl_rise ? 1'b0 : err_overflow;
      base_seq = dl_rise ? 1'b0 : err_seq;
      in_range = ioctl_addr < ROM_END;
      wr_ok    = take && in_range;
      ovf_nxt  = base_ovf | (take & ~in_range);
      seq_nxt  = base_seq | (wr_ok && (ioctl_addr != base_exp));
      exp_nxt  = wr_ok ? ioctl_addr + 25'd1 : base_exp;
      cnt_nxt  = (wr_ok && base_cnt != '1) ? base_cnt + 18'd1 : base_cnt;

      state_nxt = state;
      hold_nxt  = hold_cnt;
      ok_nxt    = rom_ok;
      if (dl_rise) begin
         state_nxt = S_LOAD;
         ok_nxt    = 1'b0;
      end else begin
         case (state)
            S_IDLE: ;
            S_LOAD:
               if (dl_fall) begin
                  state_nxt = S_HOLD;
                  hold_nxt  = HOLD_LD;
                  ok_nxt    = (cnt_nxt == ROM_LEN) && !ovf_nxt && !seq_nxt;
               end
            S_HOLD:
               if (!rom_ok)                state_nxt = S_FAULT;
               else if (ext_reset)         hold_nxt  = HOLD_LD;
               else if (hold_cnt == '0)    state_nxt = S_RUN;
               else                        hold_nxt  = hold_cnt - 16'd1;
            S_RUN:
               if (ext_reset) begin
                  state_nxt = S_HOLD;
                  hold_nxt  = HOLD_LD;
               end
            S_FAULT: ;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // dl_q resets high so a download already in progress is not seen as a new rising edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         dl_q         <= 1'b1;
         exp_addr     <= '0;
         hold_cnt     <= '0;
         byte_count   <= '0;
         err_overflow <= 1'b0;
         err_seq      <= 1'b0;
         rom_ok       <= 1'b0;
         dn_wr        <= 1'b0;
         dn_addr      <= '0;
         dn_data      <= '0;
      end else begin
         state        <= state_nxt;
         dl_q         <= ioctl_download;
         exp_addr     <= exp_nxt;
         hold_cnt     <= hold_nxt;
         byte_count   <= cnt_nxt;
         err_overflow <= ovf_nxt;
         err_seq      <= seq_nxt;
         rom_ok       <= ok_nxt;
         dn_wr        <= wr_ok;
         if (wr_ok) begin
            dn_addr <= ioctl_addr[16:0];
            dn_data <= ioctl_dout;
         end
      end
   end

endmodule

// File: tb/tb_btime_rom_loader.sv
// Randomized bench for btime_rom_loader: a download-session model predicts every output
// each cycle, plus literal checks on reset values, flags and reset-release timing.
module tb_btime_rom_loader;

   localparam int unsigned ROM  = 300;
   localparam int unsigned HOLD = 20;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ext_reset = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr, game_reset, rom_ok, err_overflow, err_seq;
   logic [17:0] byte_count;

   btime_rom_loader #(.ROM_SIZE(ROM), .RESET_HOLD(HOLD)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ext_reset(ext_reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
      .game_reset(game_reset), .rom_ok(rom_ok), .err_overflow(err_overflow),
      .err_seq(err_seq), .byte_count(byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int wr_pulses = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Session model: a download is a window of bytes; a good window releases the game
   // HOLD edges after it closes, and any later ext_reset pushes the release edge out.
   bit          m_prev = 1'b1, m_loading = 1'b0, m_ok = 1'b0, m_ovf = 1'b0, m_seq = 1'b0, m_wr = 1'b0;
   int          m_cnt = 0, m_next = 0, m_release = 0;
   logic [16:0] m_addr = '0;
   logic [7:0]  m_data = '0;

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         m_prev = 1'b1; m_loading = 1'b0; m_ok = 1'b0; m_ovf = 1'b0; m_seq = 1'b0;
         m_wr = 1'b0; m_cnt = 0; m_next = 0; m_release = 0; m_addr = '0; m_data = '0;
      end else begin
         int  e;
         bit  rise, fall;
         e      = cyc + 1;
         rise   = ioctl_download && !m_prev;
         fall   = !ioctl_download && m_prev;
         m_prev = ioctl_download;
         m_wr   = 1'b0;
         if (rise) begin
            m_loading = 1'b1; m_cnt = 0; m_ovf = 1'b0; m_seq = 1'b0; m_ok = 1'b0; m_next = 0;
         end else if (!m_loading && m_ok && ext_reset) begin
            m_release = e + HOLD;
         end
         if (m_loading && ioctl_wr) begin
            if (ioctl_addr >= 25'(ROM)) m_ovf = 1'b1;
            else begin
               if (int'(ioctl_addr) != m_next) m_seq = 1'b1;
               m_wr   = 1'b1;
               m_addr = ioctl_addr[16:0];
               m_data = ioctl_dout;
               if (m_cnt < 262143) m_cnt++;
               m_next = int'(ioctl_addr) + 1;
            end
         end
         if (m_loading && fall) begin
            m_loading = 1'b0;
            m_ok      = (m_cnt == ROM) && !m_ovf && !m_seq;
            m_release = e + HOLD;
         end
      end
   end

   always @(negedge clk_sys) begin
      bit egr;
      egr = !(m_ok && !m_loading && cyc >= m_release);
      if (dn_wr === 1'b1) wr_pulses++;
      tests++;
      if (dn_wr !== m_wr || dn_addr !== m_addr || dn_data !== m_data || game_reset !== egr ||
          rom_ok !== m_ok || err_overflow !== m_ovf || err_seq !== m_seq ||
          byte_count !== 18'(m_cnt)) begin
         fails++;
         $display("FAIL model_cmp cyc=%0d got wr=%b a=%h d=%h gr=%b ok=%b ovf=%b seq=%b cnt=%0d exp wr=%b a=%h d=%h gr=%b ok=%b ovf=%b seq=%b cnt=%0d",
                  cyc, dn_wr, dn_addr, dn_data, game_reset, rom_ok, err_overflow, err_seq, byte_count,
                  m_wr, m_addr, m_data, egr, m_ok, m_ovf, m_seq, m_cnt);
      end
   end

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic wait_low(input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk_sys);
         if (game_reset == 1'b0) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         tests++;
         fails++;
         $display("FAIL wait_release timeout got=high exp=low within %0d cycles", budget);
      end
   endtask

   function automatic logic [24:0] addr_of(input int i, input int kind, input int n);
      int a;
      a = i;
      if (kind == 1 && i >= 2) a = (i == n - 1) ? 2 : i + 1;
      if (kind == 3 && i == n - 1) return 25'h1000005;
      return 25'(a);
   endfunction

   // kind 0: sequential, 1: gap at 2 patched in last, 3: last byte has upper address bits set
   task automatic download(input int n, input int kind, input bit first_on_rise,
                           input bit drop_with_last, output int fall_edge);
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      if (!first_on_rise) begin
         ioctl_wr = 1'b0;
         @(negedge clk_sys);
      end
      fall_edge = -1;
      for (int i = 0; i < n; i++) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = addr_of(i, kind, n);
         ioctl_dout = 8'($urandom);
         if (i == n - 1 && drop_with_last) begin
            ioctl_download = 1'b0;
            fall_edge      = cyc + 1;
         end
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
         if ($urandom_range(0, 3) == 0) @(negedge clk_sys);
      end
      if (fall_edge < 0) fall_edge = cyc + 1;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      @(negedge clk_sys);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe, at, last_high, nxt;
      bit dl;

      repeat (3) @(negedge clk_sys);
      check("rst_game_reset", int'(game_reset), 1);
      check("rst_dn_wr", int'(dn_wr), 0);
      check("rst_dn_addr", int'(dn_addr), 0);
      check("rst_dn_data", int'(dn_data), 0);
      check("rst_rom_ok", int'(rom_ok), 0);
      check("rst_flags", int'({err_overflow, err_seq}), 0);
      check("rst_byte_count", int'(byte_count), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // clean image, first byte on the rising edge, last byte on the falling edge
      wr_pulses = 0;
      download(ROM, 0, 1'b1, 1'b1, fe);
      check("clean_rom_ok", int'(rom_ok), 1);
      check("clean_count", int'(byte_count), ROM);
      check("clean_wr_pulses", wr_pulses, ROM);
      check("clean_flags", int'({err_overflow, err_seq}), 0);
      wait_low(HOLD + 10, at);
      if (at >= 0) check("clean_release_delay", at - fe, HOLD);

      // ext_reset for 5 cycles while running
      @(negedge clk_sys);
      ext_reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         if (i == 0) check("ext_reset_immediate", int'(game_reset), 1);
      end
      last_high = cyc;
      ext_reset = 1'b0;
      wait_low(HOLD + 10, at);
      if (at >= 0) check("ext_release_delay", at - last_high, HOLD);
      check("ext_rom_ok_kept", int'(rom_ok), 1);

      // one byte past the end of the image
      wr_pulses = 0;
      download(ROM + 1, 0, 1'b0, 1'b0, fe);
      repeat (HOLD + 5) @(negedge clk_sys);
      check("ovf_flag", int'(err_overflow), 1);
      check("ovf_rom_ok", int'(rom_ok), 0);
      check("ovf_count", int'(byte_count), ROM);
      check("ovf_wr_pulses", wr_pulses, ROM);
      check("ovf_game_reset", int'(game_reset), 1);

      // upper address bits must not alias into the ROM space
      wr_pulses = 0;
      download(ROM, 3, 1'b0, 1'b1, fe);
      repeat (4) @(negedge clk_sys);
      check("hibit_ovf", int'(err_overflow), 1);
      check("hibit_wr_pulses", wr_pulses, ROM - 1);
      check("hibit_game_reset", int'(game_reset), 1);

      // correct length but out-of-order addresses
      download(ROM, 1, 1'b0, 1'b0, fe);
      repeat (HOLD + 5) @(negedge clk_sys);
      check("seq_flag", int'(err_seq), 1);
      check("seq_no_ovf", int'(err_overflow), 0);
      check("seq_rom_ok", int'(rom_ok), 0);
      check("seq_count", int'(byte_count), ROM);
      check("seq_game_reset", int'(game_reset), 1);

      download(ROM, 0, 1'b0, 1'b0, fe);
      wait_low(HOLD + 10, at);
      check("recover_count", int'(byte_count), ROM);

      // reset_n mid-download
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < 100; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'($urandom);
         @(negedge clk_sys);
      end
      ioctl_wr = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("midrst_game_reset", int'(game_reset), 1);
      check("midrst_rom_ok", int'(rom_ok), 0);
      check("midrst_flags", int'({err_overflow, err_seq, dn_wr}), 0);
      check("midrst_count", int'(byte_count), 0);
      @(negedge clk_sys);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_sys);
         ioctl_wr = 1'b1; ioctl_addr = 25'(100 + i);
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check("midrst_ignored_count", int'(byte_count), 0);
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      download(ROM, 0, 1'b0, 1'b0, fe);
      wait_low(HOLD + 10, at);
      check("midrst_second_count", int'(byte_count), ROM);

      // random traffic: sparse address errors, ext_reset pulses, download toggles
      dl  = 1'b0;
      nxt = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_sys);
         ioctl_wr  = 1'b0;
         ext_reset = ($urandom_range(0, 39) == 0);
         if (dl) begin
            if ($urandom_range(0, 1) == 0) begin
               ioctl_wr   = 1'b1;
               ioctl_addr = ($urandom_range(0, 299) == 0) ? 25'($urandom_range(0, ROM + 3)) : 25'(nxt);
               ioctl_dout = 8'($urandom);
               nxt++;
            end
            if (nxt >= int'(ROM) || $urandom_range(0, 400) == 0) dl = 1'b0;
         end else if ($urandom_range(0, 60) == 0) begin
            dl  = 1'b1;
            nxt = 0;
         end
         ioctl_download = dl;
      end
      @(negedge clk_sys);
      ioctl_download = 1'b0; ioctl_wr = 1'b0; ext_reset = 1'b0;
      repeat (HOLD + 5) @(negedge clk_sys);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
